instr_sequencer: RTL and testbench

- Multi-cycle fetch/execute controller for the 9-bit ISA core.
- Drives the instruction ROM address and latches the fetched word into an instruction register (Ir). Ir feeds the combinational control decoder.
- Gates the decoder's enables into single-cycle commit strobes and runs a req/ack handshake with data memory for LOAD/STORE.
- Resolves branches and halts the core.

---
 rtl/instr_sequencer.sv | 168 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for the 9-bit ISA core.
// Owns PC and Ir, gates commit strobes and runs the data-memory handshake.
`timescale 1ns/1ps
module instr_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [8:0]          Instruction,
  output logic [PC_WIDTH-1:0] Instr_addr,
  output logic [8:0]          Ir,
  input  logic                Dec_reg_write_en,
  input  logic                Dec_data_read_en,
  input  logic                Dec_data_write_en,
  input  logic                Zero_flag,
  output logic                Reg_write_commit,
  output logic                Flag_latch_en,
  output logic                Mem_req,
  output logic                Mem_we,
  input  logic                Mem_ack,
  output logic                Busy,
  output logic                Done,
  output logic                Error
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [8:0] HALT_WORD = 9'b0_0_1_000000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nx;
  logic [8:0]          r_ir;
  logic                w_ir_ld;
  logic [TW-1:0]       r_cnt;
  logic [TW-1:0]       w_cnt_nx;
  logic                r_err;
  logic                w_err_nx;
  logic                r_we;
  logic                w_we_nx;
  logic                w_commit;
  logic                w_flag;

  logic                w_op_data;
  logic                w_op_branch;
  logic                w_op_alu;
  logic                w_taken;
  logic                w_halt;
  logic [PC_WIDTH-1:0] w_offset;
  logic [PC_WIDTH-1:0] w_pc_inc;

  assign w_op_data   = Dec_data_read_en | Dec_data_write_en;
  assign w_op_branch = !w_op_data & !r_ir[8] & r_ir[6];
  assign w_op_alu    = !w_op_data & !w_op_branch;
  assign w_taken     = !r_ir[7] | Zero_flag;
  assign w_halt      = (r_ir == HALT_WORD);
  assign w_offset    = PC_WIDTH'($signed(r_ir[5:0]));
  assign w_pc_inc    = r_pc + PC_WIDTH'(1);

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_ir_ld    = 1'b0;
    w_cnt_nx   = r_cnt;
    w_err_nx   = r_err;
    w_we_nx    = r_we;
    w_commit   = 1'b0;
    w_flag     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_pc_nx    = '0;
          w_state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        w_ir_ld    = 1'b1;
        w_state_nx = S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          w_op_data: begin
            w_cnt_nx   = '0;
            w_we_nx    = Dec_data_write_en;
            w_state_nx = S_MEM;
          end
          w_op_branch: begin
            if (w_halt) begin
              w_state_nx = S_HALT;
            end else begin
              w_pc_nx    = w_taken ? (r_pc + w_offset) : w_pc_inc;
              w_state_nx = S_FETCH;
            end
          end
          w_op_alu: begin
            w_commit   = Dec_reg_write_en;
            w_flag     = !r_ir[8] & !r_ir[6];
            w_pc_nx    = w_pc_inc;
            w_state_nx = S_FETCH;
          end
          default: w_state_nx = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (Mem_ack) begin
          w_commit   = Dec_data_read_en;
          w_pc_nx    = w_pc_inc;
          w_state_nx = S_FETCH;
        end else if (r_cnt == TW'(MEM_TIMEOUT - 1)) begin
          // give up: no commit, PC left on the faulting access
          w_err_nx   = 1'b1;
          w_state_nx = S_HALT;
        end else begin
          w_cnt_nx = r_cnt + TW'(1);
        end
      end
      S_HALT: begin
        if (Start) begin
          w_pc_nx    = '0;
          w_err_nx   = 1'b0;
          w_state_nx = S_FETCH;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= 9'h000;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_cnt   <= w_cnt_nx;
      r_err   <= w_err_nx;
      r_we    <= w_we_nx;
      if (w_ir_ld) r_ir <= Instruction;
    end
  end

  assign Instr_addr       = r_pc;
  assign Ir               = r_ir;
  assign Reg_write_commit = w_commit;
  assign Flag_latch_en    = w_flag;
  assign Mem_req          = (r_state == S_MEM);
  assign Mem_we           = Mem_req & r_we;
  assign Busy             = (r_state == S_FETCH) |
                            (r_state == S_EXEC) |
                            (r_state == S_MEM);
  assign Done             = (r_state == S_HALT);
  assign Error            = r_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: per-cycle expected snapshots
// queued by the stimulus, popped and compared on the falling edge.
`timescale 1ns/1ps
module tb_instr_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [8:0] Instruction;
  logic [7:0] Instr_addr;
  logic [8:0] Ir;
  logic       Dec_reg_write_en;
  logic       Dec_data_read_en;
  logic       Dec_data_write_en;
  logic       Zero_flag;
  logic       Reg_write_commit;
  logic       Flag_latch_en;
  logic       Mem_req;
  logic       Mem_we;
  logic       Mem_ack;
  logic       Busy;
  logic       Done;
  logic       Error;

  instr_sequencer #(.PC_WIDTH(8), .MEM_TIMEOUT(15)) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .Start             (Start),
    .Instruction       (Instruction),
    .Instr_addr        (Instr_addr),
    .Ir                (Ir),
    .Dec_reg_write_en  (Dec_reg_write_en),
    .Dec_data_read_en  (Dec_data_read_en),
    .Dec_data_write_en (Dec_data_write_en),
    .Zero_flag         (Zero_flag),
    .Reg_write_commit  (Reg_write_commit),
    .Flag_latch_en     (Flag_latch_en),
    .Mem_req           (Mem_req),
    .Mem_we            (Mem_we),
    .Mem_ack           (Mem_ack),
    .Busy              (Busy),
    .Done              (Done),
    .Error             (Error)
  );

  always #5 Clk = ~Clk;

  logic [8:0] rom [256];
  assign Instruction = rom[Instr_addr];

  // toy decoder: Ir[8]=1 is memory (Ir[7]=1 store), Ir[8]=0/Ir[6]=0 is ALU
  assign Dec_data_read_en  = Ir[8] & !Ir[7];
  assign Dec_data_write_en = Ir[8] & Ir[7];
  assign Dec_reg_write_en  = (!Ir[8] & !Ir[6]) | Dec_data_read_en;

  localparam logic [8:0] ADD0  = 9'h005;
  localparam logic [8:0] ADD1  = 9'h006;
  localparam logic [8:0] ADD2  = 9'h007;
  localparam logic [8:0] ADD4  = 9'h008;
  localparam logic [8:0] ADD6  = 9'h009;
  localparam logic [8:0] LOAD  = 9'h100;
  localparam logic [8:0] STORE = 9'h180;
  localparam logic [8:0] BRZM2 = 9'h0FE;
  localparam logic [8:0] JMPM2 = 9'h07E;
  localparam logic [8:0] JMPP4 = 9'h044;
  localparam logic [8:0] HALTW = 9'h040;

  // flag order {commit, flag, req, we, busy, done, err}
  localparam logic [6:0] IDL  = 7'b0000000;
  localparam logic [6:0] BSY  = 7'b0000100;
  localparam logic [6:0] ALU  = 7'b1100100;
  localparam logic [6:0] REQ  = 7'b0010100;
  localparam logic [6:0] REQW = 7'b0011100;
  localparam logic [6:0] LDC  = 7'b1010100;
  localparam logic [6:0] HLT  = 7'b0000010;
  localparam logic [6:0] HLTE = 7'b0000011;

  typedef struct packed {
    logic [7:0] addr;
    logic [8:0] ir;
    logic [6:0] fl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   snap   = 0;

  function automatic exp_t S(input logic [7:0] a, input logic [8:0] ir,
                             input logic [6:0] fl);
    exp_t r;
    r.addr = a;
    r.ir   = ir;
    r.fl   = fl;
    return r;
  endfunction

  task automatic cyc(input logic st, input logic ak, input logic z,
                     input exp_t e);
    Start     = st;
    Mem_ack   = ak;
    Zero_flag = z;
    q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t ex;
      exp_t act;
      ex  = q.pop_front();
      act = S(Instr_addr, Ir, {Reg_write_commit, Flag_latch_en, Mem_req,
                               Mem_we, Busy, Done, Error});
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL snap%0d: got addr=%0d ir=%h fl=%b, exp addr=%0d ir=%h fl=%b",
                 snap, act.addr, act.ir, act.fl, ex.addr, ex.ir, ex.fl);
      end
      snap++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'h000;
    rom[0]    = LOAD;
    Reset     = 1'b0;
    Start     = 1'b0;
    Mem_ack   = 1'b0;
    Zero_flag = 1'b0;
    @(posedge Clk);
    #1;
    // reset, then abort a load mid-MEM
    cyc(0, 0, 0, S(0, 9'h000, IDL));
    cyc(0, 0, 0, S(0, 9'h000, IDL));
    Reset = 1'b1;
    cyc(0, 0, 0, S(0, 9'h000, IDL));
    cyc(1, 0, 0, S(0, 9'h000, IDL));
    cyc(0, 0, 0, S(0, 9'h000, BSY));
    cyc(0, 0, 0, S(0, LOAD, BSY));
    cyc(0, 0, 0, S(0, LOAD, REQ));
    Reset = 1'b0;
    cyc(0, 0, 0, S(0, 9'h000, IDL));
    Reset = 1'b1;
    cyc(0, 0, 0, S(0, 9'h000, IDL));

    // main program
    rom[0] = ADD0;
    rom[1] = ADD1;
    rom[2] = ADD2;
    rom[3] = LOAD;
    rom[4] = ADD4;
    rom[5] = BRZM2;
    rom[6] = ADD6;
    rom[7] = HALTW;
    cyc(1, 0, 0, S(0, 9'h000, IDL));
    cyc(0, 0, 0, S(0, 9'h000, BSY));
    cyc(0, 0, 0, S(0, ADD0, ALU));
    cyc(0, 0, 0, S(1, ADD0, BSY));
    cyc(0, 0, 0, S(1, ADD1, ALU));
    cyc(0, 0, 0, S(2, ADD1, BSY));
    cyc(0, 0, 0, S(2, ADD2, ALU));
    cyc(0, 0, 0, S(3, ADD2, BSY));
    cyc(0, 0, 0, S(3, LOAD, BSY));
    cyc(0, 0, 0, S(3, LOAD, REQ));
    cyc(0, 0, 0, S(3, LOAD, REQ));
    cyc(0, 1, 0, S(3, LOAD, LDC));
    cyc(0, 1, 0, S(4, LOAD, BSY));
    cyc(1, 0, 0, S(4, ADD4, ALU));
    cyc(0, 0, 0, S(5, ADD4, BSY));
    cyc(0, 0, 1, S(5, BRZM2, BSY));
    cyc(0, 0, 0, S(3, BRZM2, BSY));
    cyc(0, 0, 0, S(3, LOAD, BSY));
    cyc(0, 1, 0, S(3, LOAD, LDC));
    cyc(0, 0, 0, S(4, LOAD, BSY));
    cyc(0, 0, 0, S(4, ADD4, ALU));
    cyc(0, 0, 0, S(5, ADD4, BSY));
    cyc(0, 0, 0, S(5, BRZM2, BSY));
    cyc(0, 0, 0, S(6, BRZM2, BSY));
    cyc(0, 0, 0, S(6, ADD6, ALU));
    cyc(0, 0, 0, S(7, ADD6, BSY));
    cyc(0, 0, 0, S(7, HALTW, BSY));
    cyc(0, 0, 0, S(7, HALTW, HLT));
    cyc(0, 1, 1, S(7, HALTW, HLT));

    // wrap through 254 into a store that never acks
    rom[0]   = JMPM2;
    rom[254] = JMPP4;
    rom[2]   = STORE;
    cyc(1, 0, 0, S(7, HALTW, HLT));
    cyc(0, 0, 0, S(0, HALTW, BSY));
    cyc(0, 0, 0, S(0, JMPM2, BSY));
    cyc(0, 0, 0, S(254, JMPM2, BSY));
    cyc(0, 0, 0, S(254, JMPP4, BSY));
    cyc(0, 0, 0, S(2, JMPP4, BSY));
    cyc(0, 0, 0, S(2, STORE, BSY));
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, S(2, STORE, REQW));
    cyc(0, 0, 0, S(2, STORE, HLTE));
    cyc(0, 0, 0, S(2, STORE, HLTE));

    // restart clears Error
    rom[0] = HALTW;
    cyc(1, 0, 0, S(2, STORE, HLTE));
    cyc(0, 0, 0, S(0, STORE, BSY));
    cyc(0, 0, 0, S(0, HALTW, BSY));
    cyc(0, 0, 0, S(0, HALTW, HLT));

    @(negedge Clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, exp 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
